// File: rtl/pixel_write_arbiter.sv
// N-source pixel-write arbiter (fixed-priority or round-robin) feeding a small
// elastic FIFO toward the output controller, with an end-of-frame drain handshake.
module pixel_write_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int ADDR_W     = 17,
  parameter int COLOR_W    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           prio_mode,
  input  logic [NUM_SRC-1:0]             src_write,
  input  logic [NUM_SRC*ADDR_W-1:0]      src_addr,
  input  logic [NUM_SRC*3*COLOR_W-1:0]   src_rgb,
  output logic [NUM_SRC-1:0]             src_ready,
  output logic                           out_write,
  output logic [ADDR_W-1:0]              out_addr,
  output logic [COLOR_W-1:0]             out_r,
  output logic [COLOR_W-1:0]             out_g,
  output logic [COLOR_W-1:0]             out_b,
  input  logic                           out_busy,
  input  logic                           flush_req,
  output logic                           flush_done,
  output logic [15:0]                    overflow_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int REQ_W = $clog2(NUM_SRC + 1);
  localparam int RGB_W = 3 * COLOR_W;
  localparam int PIX_W = ADDR_W + RGB_W;

  typedef enum logic {IDLE, DRAIN} flush_state_t;

  logic [PIX_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [SRC_W-1:0] last_grant, grant_idx;
  logic [NUM_SRC-1:0] grant;
  logic [PIX_W-1:0] push_pix, head_pix, hold_pix;
  logic [REQ_W-1:0] req_cnt;
  logic found, full, push, pop, starve;
  flush_state_t state;

  // Full comes from the registered count, so a same-cycle pop never frees a slot early.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    push_pix  = '0;
    full      = (count == CNT_W'(FIFO_DEPTH));
    if (reset && !full) begin
      if (prio_mode) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (src_write[i]) begin
            found     = 1'b1;
            grant_idx = SRC_W'(i);
            push_pix  = {src_addr[i*ADDR_W +: ADDR_W], src_rgb[i*RGB_W +: RGB_W]};
          end
        end
      end else begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (!found && src_write[i] && (i > int'(last_grant))) begin
            found     = 1'b1;
            grant_idx = SRC_W'(i);
            push_pix  = {src_addr[i*ADDR_W +: ADDR_W], src_rgb[i*RGB_W +: RGB_W]};
          end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
          if (!found && src_write[i]) begin
            found     = 1'b1;
            grant_idx = SRC_W'(i);
            push_pix  = {src_addr[i*ADDR_W +: ADDR_W], src_rgb[i*RGB_W +: RGB_W]};
          end
        end
      end
    end
    grant = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      grant[i] = found && (grant_idx == SRC_W'(i));
    end
  end

  always_comb begin
    req_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      req_cnt = req_cnt + REQ_W'(src_write[i]);
    end
  end

  assign src_ready = grant;
  assign push      = found;
  assign out_write = (count != '0);
  assign pop       = out_write && !out_busy;
  assign starve    = (req_cnt > REQ_W'(push));
  assign head_pix  = out_write ? mem[rd_ptr] : hold_pix;
  assign out_addr  = head_pix[PIX_W-1 -: ADDR_W];
  assign out_r     = head_pix[RGB_W-1 -: COLOR_W];
  assign out_g     = head_pix[2*COLOR_W-1 -: COLOR_W];
  assign out_b     = head_pix[COLOR_W-1:0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_pix;
  end

  // hold_pix tracks the head so the outputs keep the last pixel once the FIFO empties.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      last_grant   <= SRC_W'(NUM_SRC - 1);
      hold_pix     <= '0;
      overflow_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + PTR_W'(1);
        last_grant <= grant_idx;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (out_write) hold_pix <= mem[rd_ptr];
      if (starve && (overflow_cnt != 16'hFFFF)) overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        IDLE: if (flush_req) state <= DRAIN;
        DRAIN: begin
          if ((count == '0) && !push) begin
            state      <= IDLE;
            flush_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Scoreboard bench for pixel_write_arbiter: a reference model predicts grants,
// FIFO contents, flush_done and overflow_cnt and is compared every cycle.
module tb_pixel_write_arbiter;
  localparam int NUM_SRC    = 2;
  localparam int ADDR_W     = 17;
  localparam int COLOR_W    = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int PIX_W      = ADDR_W + 3*COLOR_W;

  logic clk, reset, prio_mode, out_busy, flush_req;
  logic [NUM_SRC-1:0] src_write, src_ready;
  logic [NUM_SRC*ADDR_W-1:0] src_addr;
  logic [NUM_SRC*3*COLOR_W-1:0] src_rgb;
  logic out_write, flush_done;
  logic [ADDR_W-1:0] out_addr;
  logic [COLOR_W-1:0] out_r, out_g, out_b;
  logic [15:0] overflow_cnt;

  int checks = 0;
  int errors = 0;
  int fd_pulses = 0;

  logic [PIX_W-1:0] pend0[$], pend1[$], m_q[$];
  logic [ADDR_W-1:0] popped[$];
  int m_last, m_ovf;
  bit m_drain, m_fdone;

  pixel_write_arbiter #(.NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W),
                        .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .prio_mode(prio_mode), .src_write(src_write),
    .src_addr(src_addr), .src_rgb(src_rgb), .src_ready(src_ready),
    .out_write(out_write), .out_addr(out_addr), .out_r(out_r), .out_g(out_g),
    .out_b(out_b), .out_busy(out_busy), .flush_req(flush_req),
    .flush_done(flush_done), .overflow_cnt(overflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic bit req_of(input int c);
    return ((int'(src_write) >> c) & 1) == 1;
  endfunction

  // Reference model: evaluated mid-cycle, then advanced to the state after the next edge.
  always @(negedge clk) begin : monitor
    int g, reqs;
    bit push, pop;
    if (!reset) begin
      m_q.delete();
      m_last  = NUM_SRC - 1;
      m_drain = 0;
      m_fdone = 0;
      m_ovf   = 0;
      check_output("rst_out_write", out_write, 0);
      check_output("rst_src_ready", src_ready, 0);
      check_output("rst_flush_done", flush_done, 0);
    end else begin
      g = -1;
      if (m_q.size() < FIFO_DEPTH) begin
        if (prio_mode) begin
          for (int i = NUM_SRC-1; i >= 0; i--) if (g < 0 && req_of(i)) g = i;
        end else begin
          for (int k = 1; k <= NUM_SRC; k++)
            if (g < 0 && req_of((m_last + k) % NUM_SRC)) g = (m_last + k) % NUM_SRC;
        end
      end
      check_output("src_ready", src_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
      check_output("out_write", out_write, m_q.size() != 0);
      if (m_q.size() != 0) begin
        check_output("out_addr", out_addr, m_q[0][PIX_W-1 -: ADDR_W]);
        check_output("out_rgb", {out_r, out_g, out_b}, m_q[0][3*COLOR_W-1:0]);
      end
      check_output("flush_done", flush_done, m_fdone);
      check_output("overflow_cnt", overflow_cnt, m_ovf);
      if (flush_done) fd_pulses++;
      push = (g >= 0);
      pop  = (m_q.size() != 0) && !out_busy;
      reqs = 0;
      for (int i = 0; i < NUM_SRC; i++) if (req_of(i)) reqs++;
      if (reqs > (push ? 1 : 0) && m_ovf < 65535) m_ovf++;
      m_fdone = 0;
      if (!m_drain) begin
        if (flush_req) m_drain = 1;
      end else if (m_q.size() == 0 && !push) begin
        m_drain = 0;
        m_fdone = 1;
      end
      if (pop) begin
        popped.push_back(m_q[0][PIX_W-1 -: ADDR_W]);
        void'(m_q.pop_front());
      end
      if (push) begin
        m_q.push_back({src_addr[g*ADDR_W +: ADDR_W], src_rgb[g*3*COLOR_W +: 3*COLOR_W]});
        m_last = g;
      end
    end
  end

  task automatic apply_stimulus();
    src_write[0] = (pend0.size() != 0);
    src_write[1] = (pend1.size() != 0);
    if (pend0.size() != 0) begin
      src_addr[0*ADDR_W +: ADDR_W] = pend0[0][PIX_W-1 -: ADDR_W];
      src_rgb[0 +: 24]             = pend0[0][23:0];
    end
    if (pend1.size() != 0) begin
      src_addr[1*ADDR_W +: ADDR_W] = pend1[0][PIX_W-1 -: ADDR_W];
      src_rgb[24 +: 24]            = pend1[0][23:0];
    end
  endtask

  // Sources hold each request until it is seen accepted at a clock edge.
  task automatic cycle();
    bit acc0, acc1;
    @(negedge clk);
    acc0 = src_write[0] && src_ready[0];
    acc1 = src_write[1] && src_ready[1];
    @(posedge clk);
    #1;
    if (acc0) void'(pend0.pop_front());
    if (acc1) void'(pend1.pop_front());
    apply_stimulus();
  endtask

  task automatic run_until_idle(input int budget);
    int c = 0;
    while ((pend0.size() + pend1.size()) != 0 && c < budget) begin
      cycle();
      c++;
    end
    check_output("drive_done", pend0.size() + pend1.size(), 0);
  endtask

  initial begin
    int fd_base;
    reset = 1'b0; prio_mode = 1'b0; out_busy = 1'b0; flush_req = 1'b0;
    src_write = '0; src_addr = '0; src_rgb = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_out_addr", out_addr, 0);
    check_output("rst_out_rgb", {out_r, out_g, out_b}, 0);
    reset = 1'b1;

    // Single write latency
    pend0.push_back({17'h00010, 24'h112233});
    apply_stimulus();
    run_until_idle(10);
    repeat (3) cycle();

    // Fixed priority: source 1 wins while both request
    prio_mode = 1'b1;
    for (int i = 0; i < 4; i++) pend1.push_back({17'd2, 24'hA0A0A0 + 24'(i)});
    pend0.push_back({17'd1, 24'h010101});
    apply_stimulus();
    run_until_idle(20);
    repeat (2) cycle();
    check_output("fixed_overflow", overflow_cnt, 4);

    // Output stall: only FIFO_DEPTH accepted
    prio_mode = 1'b0;
    out_busy  = 1'b1;
    for (int i = 0; i < 6; i++) pend0.push_back({17'h300 + 17'(i), 24'h300000 + 24'(i)});
    apply_stimulus();
    repeat (8) cycle();
    check_output("stall_pending", pend0.size(), 2);
    out_busy = 1'b0;
    run_until_idle(20);
    repeat (3) cycle();

    // Flush while stalled
    out_busy = 1'b1;
    for (int i = 0; i < 3; i++) pend0.push_back({17'h400 + 17'(i), 24'h400000 + 24'(i)});
    apply_stimulus();
    run_until_idle(10);
    fd_base = fd_pulses;
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    repeat (4) cycle();
    check_output("flush_while_stalled", fd_pulses - fd_base, 0);
    out_busy = 1'b0;
    repeat (6) cycle();
    check_output("flush_pulses", fd_pulses - fd_base, 1);

    // Reset with pending flush and queued data
    out_busy = 1'b1;
    for (int i = 0; i < 3; i++) pend0.push_back({17'h500 + 17'(i), 24'h500000 + 24'(i)});
    apply_stimulus();
    run_until_idle(10);
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    cycle();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_output("async_rst_out_write", out_write, 0);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    out_busy = 1'b0;
    fd_base  = fd_pulses;
    repeat (4) cycle();
    check_output("no_flush_after_reset", fd_pulses - fd_base, 0);
    pend1.push_back({17'h00055, 24'h555555});
    apply_stimulus();
    run_until_idle(10);
    repeat (2) cycle();

    // Round-robin alternation
    prio_mode = 1'b0;
    popped.delete();
    pend0.push_back({17'd100, 24'h640000});
    pend0.push_back({17'd101, 24'h650000});
    pend1.push_back({17'd200, 24'hC80000});
    pend1.push_back({17'd201, 24'hC90000});
    apply_stimulus();
    run_until_idle(10);
    repeat (3) cycle();
    check_output("rr_pop_count", popped.size(), 4);
    if (popped.size() == 4) begin
      check_output("rr_addr0", popped[0], 100);
      check_output("rr_addr1", popped[1], 200);
      check_output("rr_addr2", popped[2], 101);
      check_output("rr_addr3", popped[3], 201);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_write_arbiter.md
# pixel_write_arbiter

Parametrised N-source pixel-write arbiter and elastic buffer between the pixel producers and the output controller. Pixel producers include the alpha blender and debug/host frame-buffer writers. It generalises the fixed two-way "debug write overrides blender" mux into an arbiter with these features:
- selectable fixed-priority or round-robin grant;
- a per-source valid/ready handshake;
- a FIFO that absorbs output-side stalls;
- a flush handshake, so frame completion is signalled only after every accepted pixel has left.

## Interface
Parameters:
- NUM_SRC, 2, number of write sources (≥2).
- ADDR_W, 17, pixel-number width.
- COLOR_W, 8, width of each of R, G, B.
- FIFO_DEPTH, 4, entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- prio_mode  in  1  0 = round-robin, 1 = fixed priority (highest index wins, matching the debug-override rule); sampled every cycle.
- src_write  in  NUM_SRC  per-source write request; held until accepted.
- src_addr  in  NUM_SRC*ADDR_W  packed pixel numbers; source i at [i*ADDR_W +: ADDR_W].
- src_rgb  in  NUM_SRC*3*COLOR_W  packed {r,g,b} per source.
- src_ready  out  NUM_SRC  acceptance strobe, one-hot or zero.
- out_write  out  1  FIFO head valid.
- out_addr  out  ADDR_W  head pixel number.
- out_r, out_g, out_b  out  COLOR_W each  head colour.
- out_busy  in  1  downstream stall; the head is popped when out_write && !out_busy.
- flush_req  in  1  single-cycle pulse, end of frame.
- flush_done  out  1  single-cycle pulse, emitted once the FIFO has drained after a flush_req.
- overflow_cnt  out  16  saturating count of cycles with ≥1 requester not granted.

## Operation
**Grant logic (combinational)**
- full = (count == FIFO_DEPTH).
- When full: no grant, src_ready = 0.
- Fixed mode: grant the highest requesting index.
- Round-robin mode: search upward from last_grant+1, wrapping modulo NUM_SRC; grant the first requester.
- src_ready[i] = grant[i].
- A write is accepted when src_write[i] && src_ready[i]. Its address and colour are pushed at the tail that edge.
- last_grant updates only on acceptance.

**FIFO**
- Circular buffer with rd_ptr, wr_ptr and count of width $clog2(FIFO_DEPTH)+1.
- Pointers wrap from FIFO_DEPTH-1 to 0.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full is evaluated from the registered count, so no push occurs while full, even if a pop happens that cycle.
- out_* are driven from the head entry.
- out_addr/out_r/out_g/out_b are don't-care when out_write = 0; they are held at the last head value.

**Flush FSM** (states IDLE, DRAIN)
- IDLE → DRAIN on flush_req.
- DRAIN → IDLE when count == 0 and no push occurs that cycle; flush_done pulses for one cycle on that transition.
- flush_req while in DRAIN is ignored.
- flush_req with the FIFO already empty and no push that cycle: go to DRAIN, then flush_done the next cycle (latency 1).
- Writes are still accepted during DRAIN and extend the drain.

**overflow_cnt**
- Increments when (|src_write) and the number of accepted writes is less than popcount(src_write).
- Saturates at 16'hFFFF.

## Timing
- Reset asserted: count = 0, both pointers = 0, last_grant = NUM_SRC-1 (so round-robin starts at source 0), FSM = IDLE, overflow_cnt = 0. Outputs: out_write = 0, flush_done = 0, src_ready = 0 (while reset is low), out_addr/out_rgb = 0.
- Reset mid-operation discards all FIFO contents and any pending flush; no flush_done is produced.
- Latency: a write accepted at edge k, into an empty FIFO, gives out_write = 1 after edge k.
- Throughput: 1 pixel/cycle when out_busy = 0.
- out_busy held high: the head and out_write are stable. At most FIFO_DEPTH writes are accepted, after which src_ready = 0.
- prio_mode changes take effect the same cycle; last_grant is kept.

## Test plan
- Reset, then source 0 writes addr 17'h00010, rgb {8'h11,8'h22,8'h33}, out_busy = 0 → src_ready[0] = 1 in that cycle; out_write = 1 with matching data the next cycle, for exactly 1 cycle.
- Fixed mode, both sources request every cycle (addr 1 and 2) → source 1 is always granted; overflow_cnt increments by 1 per cycle.
- Round-robin mode, both sources request continuously for 4 cycles → grants 0,1,0,1; out_addr sequence 100,200,101,201.
- out_busy = 1, source 0 offers 6 writes → exactly 4 accepted, src_ready = 0 afterwards. After out_busy drops: 4 pops in order, then the remaining 2 are accepted.
- 3 pixels queued, out_busy = 1, flush_req pulsed → no flush_done while stalled. After release, flush_done pulses exactly once, one cycle after the last pop.
- reset asserted with 3 entries and DRAIN pending → out_write = 0 immediately (asynchronously). After release there is no flush_done, and the next write appears with latency 1.
